// File: rtl/gyro_pkg.sv
// gyro_pkg: definitions shared by the FOG receive path and the ramp path.
//   - demod_state_e  : demodulator sequencing states
//   - DEF_ADC_BIT    : default ADC sample width
//   - DEF_OUTPUT_BIT : default DAC-domain width
//   - sat_s64()      : clamps a signed value into the signed range of n bits
package gyro_pkg;

    localparam int DEF_ADC_BIT    = 14;
    localparam int DEF_OUTPUT_BIT = 16;

    typedef enum logic [1:0] {
        ACC_P,
        ACC_N,
        UPDATE
    } demod_state_e;

    // Works on a 64-bit carrier so that callers of any width can share it.
    // Callers narrow the result with a size cast.
    function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v,
                                                   input int               n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/gyro_sat_accum.sv
// gyro_sat_accum: signed saturating accumulator with clear and enable.
//   i_clk, i_rst : clock, asynchronous active-high reset (value 0)
//   i_clr        : load 0 on the next clock (has priority over i_en)
//   i_en         : add i_inc to the held value, saturating to OUT_BIT
//   i_inc        : signed increment, INC_BIT wide
//   o_q          : signed accumulated value, OUT_BIT wide (registered)
module gyro_sat_accum
    import gyro_pkg::*;
#(
    parameter int INC_BIT = 32,
    parameter int OUT_BIT = DEF_OUTPUT_BIT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic signed [INC_BIT-1:0] i_inc,
    output logic signed [OUT_BIT-1:0] o_q
);

    logic signed [OUT_BIT-1:0] q_q;
    logic signed [OUT_BIT-1:0] q_d;
    logic signed [63:0]        sum;

    always_comb begin
        sum = 64'(q_q) + 64'(i_inc);
        q_d = q_q;
        if (i_clr) begin
            q_d = '0;
        end else if (i_en) begin
            q_d = OUT_BIT'(sat_s64(sum, OUT_BIT));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/gyro_sq_demod.sv
// gyro_sq_demod: closed-loop FOG receive path. Generates square-wave bias
// modulation, demodulates the ADC stream against it, integrates the rate
// error into a ramp step and pulses a trigger once per modulation period.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_adc        : signed ADC sample, qualified by i_adc_vld
//   i_fb_on      : closed-loop enable (0 forces o_step to 0, no o_trig)
//   o_mod        : +MOD_AMP / -MOD_AMP modulation to the ramp generator
//   o_err        : demodulated error of the last complete period
//   o_err_vld    : one-clock pulse when o_err updates
//   o_step       : saturated integrated ramp step
//   o_trig       : one-clock step-apply pulse
// Build option: define GYRO_DEMOD_ERR_LPF_EN to integrate a first-order
// low-passed error (err_f += (err - err_f) >>> 3) instead of the raw error.
module gyro_sq_demod
    import gyro_pkg::*;
#(
    parameter int ADC_BIT     = DEF_ADC_BIT,
    parameter int OUTPUT_BIT  = DEF_OUTPUT_BIT,
    parameter int ACC_BIT     = 32,
    parameter int HALF_PERIOD = 100,
    parameter int DISCARD     = 8,
    parameter int GAIN_SHIFT  = 4,
    parameter int MOD_AMP     = 8192
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic signed [ADC_BIT-1:0]    i_adc,
    input  logic                         i_adc_vld,
    input  logic                         i_fb_on,
    output logic signed [OUTPUT_BIT-1:0] o_mod,
    output logic signed [ACC_BIT-1:0]    o_err,
    output logic                         o_err_vld,
    output logic signed [OUTPUT_BIT-1:0] o_step,
    output logic                         o_trig
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0]             CNT_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]             CNT_DISC = CNT_W'(DISCARD);
    localparam logic signed [OUTPUT_BIT-1:0] MOD_POS  = OUTPUT_BIT'(MOD_AMP);
    localparam logic signed [OUTPUT_BIT-1:0] MOD_NEG  = OUTPUT_BIT'(-MOD_AMP);

    demod_state_e                 state_q;
    demod_state_e                 state_d;
    logic [CNT_W-1:0]             cnt_q;
    logic [CNT_W-1:0]             cnt_d;
    logic                         phase_q;
    logic                         phase_d;
    logic signed [OUTPUT_BIT-1:0] mod_q;
    logic signed [OUTPUT_BIT-1:0] mod_d;
    logic signed [ACC_BIT-1:0]    acc_p_q;
    logic signed [ACC_BIT-1:0]    acc_p_d;
    logic signed [ACC_BIT-1:0]    acc_n_q;
    logic signed [ACC_BIT-1:0]    acc_n_d;
    logic signed [ACC_BIT-1:0]    err_q;
    logic signed [ACC_BIT-1:0]    err_d;
    logic                         err_vld_q;
    logic                         err_vld_d;
    logic                         trig_q;
    logic                         trig_d;

    logic signed [ACC_BIT-1:0]    smp;
    logic signed [ACC_BIT-1:0]    err_new;
    logic signed [ACC_BIT-1:0]    step_src;
    logic signed [ACC_BIT-1:0]    step_inc;
    logic                         step_en;
    logic                         wrap;

`ifdef GYRO_DEMOD_ERR_LPF_EN
    logic signed [ACC_BIT-1:0]    err_f_q;
    logic signed [ACC_BIT-1:0]    err_f_d;
`endif

    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        phase_d   = wrap ? ~phase_q : phase_q;
        mod_d     = phase_q ? MOD_NEG : MOD_POS;

        smp       = (i_adc_vld && (cnt_q >= CNT_DISC)) ? ACC_BIT'(i_adc) : '0;
        err_new   = acc_p_q - acc_n_q;

        state_d   = state_q;
        acc_p_d   = acc_p_q;
        acc_n_d   = acc_n_q;
        err_d     = err_q;
        err_vld_d = 1'b0;
        step_en   = 1'b0;

        case (state_q)
            ACC_P: begin
                acc_p_d = acc_p_q + smp;
                if (wrap) begin
                    state_d = ACC_N;
                end
            end
            ACC_N: begin
                acc_n_d = acc_n_q + smp;
                if (wrap) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // This clock is also the first ACC_P slot of the next period:
                // the fresh acc_p starts from this clock's sample, not from 0.
                err_d     = err_new;
                err_vld_d = 1'b1;
                acc_p_d   = smp;
                acc_n_d   = '0;
                step_en   = i_fb_on;
                state_d   = wrap ? ACC_N : ACC_P;
            end
            default: begin
                state_d = ACC_P;
            end
        endcase

`ifdef GYRO_DEMOD_ERR_LPF_EN
        err_f_d = err_f_q;
        if (state_q == UPDATE) begin
            err_f_d = err_f_q + ((err_new - err_f_q) >>> 3);
        end
        step_src = err_f_d;
`else
        step_src = err_new;
`endif
        step_inc = step_src >>> GAIN_SHIFT;
        trig_d   = step_en;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ACC_P;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            mod_q     <= MOD_POS;
            acc_p_q   <= '0;
            acc_n_q   <= '0;
            err_q     <= '0;
            err_vld_q <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            mod_q     <= mod_d;
            acc_p_q   <= acc_p_d;
            acc_n_q   <= acc_n_d;
            err_q     <= err_d;
            err_vld_q <= err_vld_d;
            trig_q    <= trig_d;
        end
    end

`ifdef GYRO_DEMOD_ERR_LPF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_f_q <= '0;
        end else begin
            err_f_q <= err_f_d;
        end
    end
`endif

    // Feedback off clears the step every clock, so integration resumes from 0.
    gyro_sat_accum #(
        .INC_BIT (ACC_BIT),
        .OUT_BIT (OUTPUT_BIT)
    ) u_step (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (!i_fb_on),
        .i_en  (step_en),
        .i_inc (step_inc),
        .o_q   (o_step)
    );

    assign o_mod     = mod_q;
    assign o_err     = err_q;
    assign o_err_vld = err_vld_q;
    assign o_trig    = trig_q;

endmodule
